exe_stage: RTL and testbench
============================

EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 Parameter HAS_FORWARDING, default 1, enables MEM-to-EXE operand bypass; when 0, bypass inputs are ignored.
REQ-002 CLK  in  1  single clock; all state updates on rising edge.
REQ-003 RESET  in  1  synchronous, active-high reset.
REQ-004 FLUSH  in  1  synchronous squash of the instruction entering the EXE/MEM register.
REQ-005 Instr1_IN, Instr1_PC_IN  in  32 each  instruction word and its PC from ID.
REQ-006 OperandA1_IN, OperandB1_IN  in  32 each  register/immediate operands from ID.
REQ-007 RegisterA1_IN, RegisterB1_IN  in  5 each  source register numbers of operands A and B.
REQ-008 WriteRegister1_IN  in  5, MemWriteData1_IN  in  32, RegWrite1_IN, MemRead1_IN, MemWrite1_IN  in  1 each  destination and memory controls from ID.
REQ-009 ALU_Control1_IN  in  6  ALU operation code; ShiftAmount1_IN  in  5  shamt field.
REQ-010 Request_Alt_PC  in  1, Alt_PC  in  32  branch/jump redirect request and target resolved in ID.
REQ-011 BypassReg1_MEMEXE  in  5, BypassData1_MEMEXE  in  32, BypassValid1_MEMEXE  in  1  MEM-stage writeback bypass.
REQ-012 Instr1_OUT, Instr1_PC_OUT, ALU_result1_OUT, MemWriteData1_OUT  out  32 each; WriteRegister1_OUT  out  5; ALU_Control1_OUT  out  6; RegWrite1_OUT, MemRead1_OUT, MemWrite1_OUT  out  1 each  registered EXE/MEM outputs.
REQ-013 Alt_PC1  out  32, Request_Alt_PC1  out  1  registered redirect passed to MEM.
REQ-014 ALU_result_async1  out  32, ALU_result_async_valid1  out  1  combinational ALU result for bypass to ID.

Function
REQ-015 Effective A (B) SHALL be BypassData1_MEMEXE when HAS_FORWARDING=1, BypassValid1_MEMEXE=1, BypassReg1_MEMEXE=RegisterA1_IN (RegisterB1_IN), and that register is nonzero; otherwise OperandA1_IN (OperandB1_IN).
REQ-016 Register 0 SHALL never be forwarded.
REQ-017 ALU codes (hex), 32-bit wrap-around, no overflow traps: 00 ADD A+B; 01 SUB A-B; 02 AND; 03 OR; 04 XOR; 05 NOR; 06 SLT signed (result 1/0); 07 SLTU unsigned; 08 SLL B<<shamt; 09 SRL B>>shamt logical; 0A SRA B>>>shamt arithmetic; 0B SLLV B<<A[4:0]; 0C SRLV; 0D SRAV; 0E LUI B<<16; 0F PASS A; 10 PASS B; all other codes result 0.
REQ-018 Loads and stores use code 00; address = A+B.
REQ-019 MemWriteData1_OUT SHALL register the forwarded-B value when RegisterB1_IN matches the bypass per REQ-015, else MemWriteData1_IN.
REQ-020 ALU_result_async1 SHALL equal the ALU result in the same cycle (zero-latency combinational).
REQ-021 ALU_result_async_valid1 = RegWrite1_IN & ~MemRead1_IN & ~FLUSH (load data not yet available).
REQ-022 Every registered output SHALL update one cycle after its inputs (latency 1); there is no stall input.
REQ-023 Request_Alt_PC and Alt_PC SHALL be registered unchanged into Request_Alt_PC1/Alt_PC1.
REQ-024 FLUSH=1 at a clock edge SHALL load a bubble: all registered outputs 0, including RegWrite1_OUT, MemRead1_OUT, MemWrite1_OUT, Request_Alt_PC1.
REQ-025 RESET has priority over FLUSH; FLUSH has priority over normal capture.

Reset
REQ-026 On RESET=1 at a clock edge all registered outputs SHALL be 0 (Instr1_OUT=0 is a NOP); combinational outputs follow inputs.
REQ-027 Reset asserted mid-operation SHALL discard the in-flight instruction; first valid capture occurs on the first edge with RESET=0.

Structure
REQ-028 ALU opcode constants SHALL reside in shared package exe_pkg, also imported by ID.
REQ-029 ALU SHALL be a purely combinational sub-module exe_alu (A, B, shamt, op -> result); forwarding muxes and the EXE/MEM register stay in exe_stage.

Verification
REQ-030 ADD A=5, B=7 -> ALU_result_async1=12 same cycle, ALU_result1_OUT=12 next cycle.
REQ-031 SUB A=0, B=1 -> 0xFFFFFFFF; SLT A=0xFFFFFFFF, B=1 -> 1; SLTU same operands -> 0; SRA B=0x80000000, shamt=4 -> 0xF8000000.
REQ-032 Forward: RegisterA1_IN=3, OperandA1_IN=0, bypass reg 3 valid data 0x100, ADD B=1 -> 0x101; same with bypass reg 0 -> 1.
REQ-033 Store forward: RegisterB1_IN=5, bypass reg 5 data 0xDEADBEEF, MemWrite1_IN=1 -> MemWriteData1_OUT=0xDEADBEEF next cycle.
REQ-034 Request_Alt_PC=1, Alt_PC=0x400100 with FLUSH=1 -> Request_Alt_PC1=0, RegWrite1_OUT=0 next cycle; FLUSH=0 -> Request_Alt_PC1=1, Alt_PC1=0x400100.
REQ-035 RESET=1 for one edge during a load -> all registered outputs 0; MemRead1_IN=1 -> ALU_result_async_valid1=0.

Source files
------------

// File: rtl/exe_pkg.sv
// Shared EXE-stage definitions: ALU opcodes (also used by ID decode) and
// the EXE/MEM pipeline register payload.
package exe_pkg;

  localparam int XLEN = 32;

  typedef logic [5:0] alu_op_t;

  localparam alu_op_t ALU_ADD   = 6'h00;
  localparam alu_op_t ALU_SUB   = 6'h01;
  localparam alu_op_t ALU_AND   = 6'h02;
  localparam alu_op_t ALU_OR    = 6'h03;
  localparam alu_op_t ALU_XOR   = 6'h04;
  localparam alu_op_t ALU_NOR   = 6'h05;
  localparam alu_op_t ALU_SLT   = 6'h06;
  localparam alu_op_t ALU_SLTU  = 6'h07;
  localparam alu_op_t ALU_SLL   = 6'h08;
  localparam alu_op_t ALU_SRL   = 6'h09;
  localparam alu_op_t ALU_SRA   = 6'h0A;
  localparam alu_op_t ALU_SLLV  = 6'h0B;
  localparam alu_op_t ALU_SRLV  = 6'h0C;
  localparam alu_op_t ALU_SRAV  = 6'h0D;
  localparam alu_op_t ALU_LUI   = 6'h0E;
  localparam alu_op_t ALU_PASSA = 6'h0F;
  localparam alu_op_t ALU_PASSB = 6'h10;

  // EXE/MEM register contents; all-zero is a bubble (instr 0 is a NOP).
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] mem_wdata;
    logic [4:0]      wreg;
    alu_op_t         alu_op;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic [XLEN-1:0] alt_pc;
    logic            req_alt_pc;
  } exe_mem_t;

  // MEM writeback matches a source register; r0 is hardwired and never bypassed.
  function automatic logic fwd_hit(input logic       byp_valid,
                                   input logic [4:0] byp_reg,
                                   input logic [4:0] src_reg);
    return byp_valid && (byp_reg == src_reg) && (src_reg != 5'd0);
  endfunction

endpackage

// File: rtl/exe_alu.sv
// Purely combinational 32-bit ALU; unknown opcodes yield zero.
module exe_alu
  import exe_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      shamt,
  input  alu_op_t         op,
  output logic [XLEN-1:0] result
);

  logic [4:0] vsh;
  assign vsh = a[4:0];

  // Opcode decode; all arithmetic wraps modulo 2^32.
  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_XOR:   result = a ^ b;
      ALU_NOR:   result = ~(a | b);
      ALU_SLT:   result = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU:  result = {31'd0, a < b};
      ALU_SLL:   result = b << shamt;
      ALU_SRL:   result = b >> shamt;
      ALU_SRA:   result = $unsigned($signed(b) >>> shamt);
      ALU_SLLV:  result = b << vsh;
      ALU_SRLV:  result = b >> vsh;
      ALU_SRAV:  result = $unsigned($signed(b) >>> vsh);
      ALU_LUI:   result = b << 16;
      ALU_PASSA: result = a;
      ALU_PASSB: result = b;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: MEM->EXE operand bypass, ALU, and the EXE/MEM register.
// The combinational ALU result is also exported for bypass back to ID.
module exe_stage
  import exe_pkg::*;
#(
  parameter bit HAS_FORWARDING = 1'b1
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            FLUSH,
  input  logic [31:0]     Instr1_IN,
  input  logic [31:0]     Instr1_PC_IN,
  input  logic [31:0]     OperandA1_IN,
  input  logic [31:0]     OperandB1_IN,
  input  logic [4:0]      RegisterA1_IN,
  input  logic [4:0]      RegisterB1_IN,
  input  logic [4:0]      WriteRegister1_IN,
  input  logic [31:0]     MemWriteData1_IN,
  input  logic            RegWrite1_IN,
  input  logic            MemRead1_IN,
  input  logic            MemWrite1_IN,
  input  logic [5:0]      ALU_Control1_IN,
  input  logic [4:0]      ShiftAmount1_IN,
  input  logic            Request_Alt_PC,
  input  logic [31:0]     Alt_PC,
  input  logic [4:0]      BypassReg1_MEMEXE,
  input  logic [31:0]     BypassData1_MEMEXE,
  input  logic            BypassValid1_MEMEXE,
  output logic [31:0]     Instr1_OUT,
  output logic [31:0]     Instr1_PC_OUT,
  output logic [31:0]     ALU_result1_OUT,
  output logic [31:0]     MemWriteData1_OUT,
  output logic [4:0]      WriteRegister1_OUT,
  output logic [5:0]      ALU_Control1_OUT,
  output logic            RegWrite1_OUT,
  output logic            MemRead1_OUT,
  output logic            MemWrite1_OUT,
  output logic [31:0]     Alt_PC1,
  output logic            Request_Alt_PC1,
  output logic [31:0]     ALU_result_async1,
  output logic            ALU_result_async_valid1
);

  logic        hit_a, hit_b;
  logic [31:0] op_a, op_b, alu_y;
  exe_mem_t    d, q;

  assign hit_a = HAS_FORWARDING && fwd_hit(BypassValid1_MEMEXE, BypassReg1_MEMEXE, RegisterA1_IN);
  assign hit_b = HAS_FORWARDING && fwd_hit(BypassValid1_MEMEXE, BypassReg1_MEMEXE, RegisterB1_IN);

  assign op_a = hit_a ? BypassData1_MEMEXE : OperandA1_IN;
  assign op_b = hit_b ? BypassData1_MEMEXE : OperandB1_IN;

  exe_alu u_alu (
    .a      (op_a),
    .b      (op_b),
    .shamt  (ShiftAmount1_IN),
    .op     (ALU_Control1_IN),
    .result (alu_y)
  );

  // Zero-latency result for ID; loads are excluded since their data comes from MEM.
  assign ALU_result_async1       = alu_y;
  assign ALU_result_async_valid1 = RegWrite1_IN & ~MemRead1_IN & ~FLUSH;

  // Next EXE/MEM contents; store data takes the bypassed B when B matches.
  always_comb begin
    d            = '0;
    d.instr      = Instr1_IN;
    d.pc         = Instr1_PC_IN;
    d.alu_result = alu_y;
    d.mem_wdata  = hit_b ? BypassData1_MEMEXE : MemWriteData1_IN;
    d.wreg       = WriteRegister1_IN;
    d.alu_op     = ALU_Control1_IN;
    d.reg_write  = RegWrite1_IN;
    d.mem_read   = MemRead1_IN;
    d.mem_write  = MemWrite1_IN;
    d.alt_pc     = Alt_PC;
    d.req_alt_pc = Request_Alt_PC;
  end

  // EXE/MEM register: reset beats flush, flush loads a bubble, else capture.
  always_ff @(posedge CLK) begin
    if (RESET)      q <= '0;
    else if (FLUSH) q <= '0;
    else            q <= d;
  end

  assign Instr1_OUT         = q.instr;
  assign Instr1_PC_OUT      = q.pc;
  assign ALU_result1_OUT    = q.alu_result;
  assign MemWriteData1_OUT  = q.mem_wdata;
  assign WriteRegister1_OUT = q.wreg;
  assign ALU_Control1_OUT   = q.alu_op;
  assign RegWrite1_OUT      = q.reg_write;
  assign MemRead1_OUT       = q.mem_read;
  assign MemWrite1_OUT      = q.mem_write;
  assign Alt_PC1            = q.alt_pc;
  assign Request_Alt_PC1    = q.req_alt_pc;

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed vectors plus randomized
// traffic against a behavioural model of the execute stage.
module tb_exe_stage;

  logic        CLK = 1'b0;
  logic        RESET, FLUSH;
  logic [31:0] Instr1_IN, Instr1_PC_IN, OperandA1_IN, OperandB1_IN;
  logic [4:0]  RegisterA1_IN, RegisterB1_IN, WriteRegister1_IN;
  logic [31:0] MemWriteData1_IN;
  logic        RegWrite1_IN, MemRead1_IN, MemWrite1_IN;
  logic [5:0]  ALU_Control1_IN;
  logic [4:0]  ShiftAmount1_IN;
  logic        Request_Alt_PC;
  logic [31:0] Alt_PC;
  logic [4:0]  BypassReg1_MEMEXE;
  logic [31:0] BypassData1_MEMEXE;
  logic        BypassValid1_MEMEXE;
  logic [31:0] Instr1_OUT, Instr1_PC_OUT, ALU_result1_OUT, MemWriteData1_OUT;
  logic [4:0]  WriteRegister1_OUT;
  logic [5:0]  ALU_Control1_OUT;
  logic        RegWrite1_OUT, MemRead1_OUT, MemWrite1_OUT;
  logic [31:0] Alt_PC1;
  logic        Request_Alt_PC1;
  logic [31:0] ALU_result_async1;
  logic        ALU_result_async_valid1;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  exe_stage #(.HAS_FORWARDING(1'b1)) dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
    .Instr1_IN(Instr1_IN), .Instr1_PC_IN(Instr1_PC_IN),
    .OperandA1_IN(OperandA1_IN), .OperandB1_IN(OperandB1_IN),
    .RegisterA1_IN(RegisterA1_IN), .RegisterB1_IN(RegisterB1_IN),
    .WriteRegister1_IN(WriteRegister1_IN), .MemWriteData1_IN(MemWriteData1_IN),
    .RegWrite1_IN(RegWrite1_IN), .MemRead1_IN(MemRead1_IN), .MemWrite1_IN(MemWrite1_IN),
    .ALU_Control1_IN(ALU_Control1_IN), .ShiftAmount1_IN(ShiftAmount1_IN),
    .Request_Alt_PC(Request_Alt_PC), .Alt_PC(Alt_PC),
    .BypassReg1_MEMEXE(BypassReg1_MEMEXE), .BypassData1_MEMEXE(BypassData1_MEMEXE),
    .BypassValid1_MEMEXE(BypassValid1_MEMEXE),
    .Instr1_OUT(Instr1_OUT), .Instr1_PC_OUT(Instr1_PC_OUT),
    .ALU_result1_OUT(ALU_result1_OUT), .MemWriteData1_OUT(MemWriteData1_OUT),
    .WriteRegister1_OUT(WriteRegister1_OUT), .ALU_Control1_OUT(ALU_Control1_OUT),
    .RegWrite1_OUT(RegWrite1_OUT), .MemRead1_OUT(MemRead1_OUT), .MemWrite1_OUT(MemWrite1_OUT),
    .Alt_PC1(Alt_PC1), .Request_Alt_PC1(Request_Alt_PC1),
    .ALU_result_async1(ALU_result_async1), .ALU_result_async_valid1(ALU_result_async_valid1)
  );

  // All registered outputs as one vector for whole-register comparisons.
  logic [174:0] obs_regs;
  assign obs_regs = {Instr1_OUT, Instr1_PC_OUT, ALU_result1_OUT, MemWriteData1_OUT,
                     WriteRegister1_OUT, ALU_Control1_OUT, RegWrite1_OUT, MemRead1_OUT,
                     MemWrite1_OUT, Alt_PC1, Request_Alt_PC1};

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_alu(input logic [5:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [4:0] sh);
    longint unsigned ua, ub;
    logic [31:0] hi;
    int sa, sb;
    ua = a; ub = b; sa = a; sb = b;
    case (op)
      6'h00: return 32'((ua + ub) % 64'h1_0000_0000);
      6'h01: return 32'((ua + 64'h1_0000_0000 - ub) % 64'h1_0000_0000);
      6'h02: return a & b;
      6'h03: return a | b;
      6'h04: return a ^ b;
      6'h05: return ~(a | b);
      6'h06: return (sa < sb) ? 32'd1 : 32'd0;
      6'h07: return (ua < ub) ? 32'd1 : 32'd0;
      6'h08: return 32'((ub * (64'd1 << sh)) % 64'h1_0000_0000);
      6'h09: return 32'(ub / (64'd1 << sh));
      6'h0A: begin
        hi = b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0;
        return 32'(ub / (64'd1 << sh)) | hi;
      end
      6'h0B: return 32'((ub * (64'd1 << a[4:0])) % 64'h1_0000_0000);
      6'h0C: return 32'(ub / (64'd1 << a[4:0]));
      6'h0D: begin
        hi = b[31] ? ~(32'hFFFF_FFFF >> a[4:0]) : 32'd0;
        return 32'(ub / (64'd1 << a[4:0])) | hi;
      end
      6'h0E: return 32'((ub * 64'd65536) % 64'h1_0000_0000);
      6'h0F: return a;
      6'h10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_fwd(input logic [4:0] r, input logic [31:0] v);
    if (BypassValid1_MEMEXE && r != 0 && BypassReg1_MEMEXE == r) return BypassData1_MEMEXE;
    return v;
  endfunction

  function automatic logic [31:0] m_async();
    return m_alu(ALU_Control1_IN, m_fwd(RegisterA1_IN, OperandA1_IN),
                 m_fwd(RegisterB1_IN, OperandB1_IN), ShiftAmount1_IN);
  endfunction

  function automatic logic m_async_valid();
    return RegWrite1_IN && !MemRead1_IN && !FLUSH;
  endfunction

  // Expected EXE/MEM contents after the next edge given current inputs.
  function automatic logic [174:0] m_regs();
    logic [31:0] wd;
    if (RESET || FLUSH) return '0;
    wd = (BypassValid1_MEMEXE && RegisterB1_IN != 0 && BypassReg1_MEMEXE == RegisterB1_IN)
         ? BypassData1_MEMEXE : MemWriteData1_IN;
    return {Instr1_IN, Instr1_PC_IN, m_async(), wd, WriteRegister1_IN, ALU_Control1_IN,
            RegWrite1_IN, MemRead1_IN, MemWrite1_IN, Alt_PC, Request_Alt_PC};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    RESET = 0; FLUSH = 0;
    Instr1_IN = 0; Instr1_PC_IN = 0; OperandA1_IN = 0; OperandB1_IN = 0;
    RegisterA1_IN = 0; RegisterB1_IN = 0; WriteRegister1_IN = 0; MemWriteData1_IN = 0;
    RegWrite1_IN = 0; MemRead1_IN = 0; MemWrite1_IN = 0;
    ALU_Control1_IN = 0; ShiftAmount1_IN = 0; Request_Alt_PC = 0; Alt_PC = 0;
    BypassReg1_MEMEXE = 0; BypassData1_MEMEXE = 0; BypassValid1_MEMEXE = 0;
  endtask

  task automatic set_alu(input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh);
    clear_inputs();
    ALU_Control1_IN = op; OperandA1_IN = a; OperandB1_IN = b; ShiftAmount1_IN = sh;
    RegWrite1_IN = 1; WriteRegister1_IN = 5'd9; Instr1_IN = 32'h0123_4567;
    Instr1_PC_IN = 32'h0040_0000;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_inputs();
    Instr1_IN = 32'hFFFF_FFFF; RegWrite1_IN = 1; MemWrite1_IN = 1; Request_Alt_PC = 1;
    Alt_PC = 32'h1234; RESET = 1;
    tick(); tick();
    checks++;
    if (obs_regs !== '0) begin
      failures++; $display("FAIL reset_regs got=%h want=0", obs_regs);
    end
  endtask

  task automatic test_alu_vectors();
    logic [5:0]  ops[5]  = '{6'h00, 6'h01, 6'h06, 6'h07, 6'h0A};
    logic [31:0] as[5]   = '{32'd5, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] bs[5]   = '{32'd7, 32'd1, 32'd1, 32'd1, 32'h8000_0000};
    logic [4:0]  shs[5]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd4};
    logic [31:0] want[5] = '{32'd12, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hF800_0000};
    for (int i = 0; i < 5; i++) begin
      set_alu(ops[i], as[i], bs[i], shs[i]);
      #1;
      checks++;
      if (ALU_result_async1 !== want[i]) begin
        failures++; $display("FAIL alu_async[%0d] got=%h want=%h", i, ALU_result_async1, want[i]);
      end
      checks++;
      if (ALU_result_async_valid1 !== 1'b1) begin
        failures++; $display("FAIL alu_async_valid[%0d] got=%b want=1", i, ALU_result_async_valid1);
      end
      tick();
      checks++;
      if (ALU_result1_OUT !== want[i]) begin
        failures++; $display("FAIL alu_reg[%0d] got=%h want=%h", i, ALU_result1_OUT, want[i]);
      end
    end
  endtask

  task automatic test_forwarding();
    logic [4:0]  breg[2] = '{5'd3, 5'd0};
    logic [31:0] want[2] = '{32'h101, 32'h1};
    for (int i = 0; i < 2; i++) begin
      set_alu(6'h00, 32'd0, 32'd1, 5'd0);
      RegisterA1_IN = breg[i]; BypassReg1_MEMEXE = breg[i];
      BypassData1_MEMEXE = 32'h100; BypassValid1_MEMEXE = 1;
      #1;
      checks++;
      if (ALU_result_async1 !== want[i]) begin
        failures++; $display("FAIL fwd_async[r%0d] got=%h want=%h", breg[i], ALU_result_async1, want[i]);
      end
      tick();
      checks++;
      if (ALU_result1_OUT !== want[i]) begin
        failures++; $display("FAIL fwd_reg[r%0d] got=%h want=%h", breg[i], ALU_result1_OUT, want[i]);
      end
    end
  endtask

  task automatic test_store_forward();
    clear_inputs();
    MemWrite1_IN = 1; RegisterB1_IN = 5'd5; MemWriteData1_IN = 32'h1111_2222;
    OperandA1_IN = 32'h1000; OperandB1_IN = 32'h8; ALU_Control1_IN = 6'h00;
    BypassReg1_MEMEXE = 5'd5; BypassData1_MEMEXE = 32'hDEAD_BEEF; BypassValid1_MEMEXE = 1;
    tick();
    checks++;
    if (MemWriteData1_OUT !== 32'hDEAD_BEEF || MemWrite1_OUT !== 1'b1) begin
      failures++; $display("FAIL store_fwd got=%h/%b want=deadbeef/1", MemWriteData1_OUT, MemWrite1_OUT);
    end
  endtask

  task automatic test_flush_redirect();
    set_alu(6'h03, 32'h0F, 32'hF0, 5'd0);
    Request_Alt_PC = 1; Alt_PC = 32'h0040_0100; FLUSH = 1;
    #1;
    checks++;
    if (ALU_result_async_valid1 !== 1'b0) begin
      failures++; $display("FAIL flush_async_valid got=%b want=0", ALU_result_async_valid1);
    end
    tick();
    checks++;
    if (obs_regs !== '0) begin
      failures++; $display("FAIL flush_bubble got=%h want=0", obs_regs);
    end
    FLUSH = 0;
    tick();
    checks++;
    if (Request_Alt_PC1 !== 1'b1 || Alt_PC1 !== 32'h0040_0100 || RegWrite1_OUT !== 1'b1) begin
      failures++; $display("FAIL redirect got=%b/%h/%b want=1/00400100/1",
                           Request_Alt_PC1, Alt_PC1, RegWrite1_OUT);
    end
  endtask

  task automatic test_reset_midload();
    set_alu(6'h00, 32'h2000, 32'h10, 5'd0);
    MemRead1_IN = 1; RESET = 1; FLUSH = 1;
    #1;
    checks++;
    if (ALU_result_async_valid1 !== 1'b0 || ALU_result_async1 !== 32'h2010) begin
      failures++; $display("FAIL load_async got=%b/%h want=0/00002010",
                           ALU_result_async_valid1, ALU_result_async1);
    end
    tick();
    checks++;
    if (obs_regs !== '0) begin
      failures++; $display("FAIL reset_midload got=%h want=0", obs_regs);
    end
    RESET = 0; FLUSH = 0;
    tick();
    checks++;
    if (MemRead1_OUT !== 1'b1 || ALU_result1_OUT !== 32'h2010) begin
      failures++; $display("FAIL load_after_reset got=%b/%h want=1/00002010", MemRead1_OUT, ALU_result1_OUT);
    end
  endtask

  task automatic test_random();
    logic [174:0] exp_r;
    logic [31:0]  exp_a;
    logic         exp_v;
    for (int n = 0; n < 400; n++) begin
      RESET = ($urandom_range(0, 15) == 0);
      FLUSH = ($urandom_range(0, 7) == 0);
      Instr1_IN = $urandom; Instr1_PC_IN = $urandom;
      OperandA1_IN = $urandom; OperandB1_IN = $urandom;
      if ($urandom_range(0, 3) == 0) OperandA1_IN = {27'd0, OperandA1_IN[4:0]};
      RegisterA1_IN = 5'($urandom_range(0, 3)); RegisterB1_IN = 5'($urandom_range(0, 3));
      WriteRegister1_IN = 5'($urandom); MemWriteData1_IN = $urandom;
      RegWrite1_IN = 1'($urandom); MemRead1_IN = 1'($urandom); MemWrite1_IN = 1'($urandom);
      ALU_Control1_IN = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'($urandom_range(0, 16));
      ShiftAmount1_IN = 5'($urandom);
      Request_Alt_PC = 1'($urandom); Alt_PC = $urandom;
      BypassReg1_MEMEXE = 5'($urandom_range(0, 3)); BypassData1_MEMEXE = $urandom;
      BypassValid1_MEMEXE = 1'($urandom);
      #1;
      exp_a = m_async(); exp_v = m_async_valid(); exp_r = m_regs();
      checks++;
      if (ALU_result_async1 !== exp_a || ALU_result_async_valid1 !== exp_v) begin
        failures++; $display("FAIL rand_async[%0d] op=%h got=%h/%b want=%h/%b", n, ALU_Control1_IN,
                             ALU_result_async1, ALU_result_async_valid1, exp_a, exp_v);
      end
      tick();
      checks++;
      if (obs_regs !== exp_r) begin
        failures++; $display("FAIL rand_regs[%0d] got=%h want=%h", n, obs_regs, exp_r);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs();
    #1;
    test_reset();
    test_alu_vectors();
    test_forwarding();
    test_store_forward();
    test_flush_redirect();
    test_reset_midload();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
